// File: rtl/clock_display_driver.sv
// rtl/clock_display_driver.sv - 24h binary time to 12h BCD, six-digit multiplexed 7-seg driver
// Optional feature macro: LEADING_ZERO_BLANK_EN (blank hour-tens digit when the 12h hour is below 10)
module clock_display_driver #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] hours,
    input  logic [5:0] mins,
    input  logic [5:0] secs,
    output logic [6:0] seg,
    output logic [5:0] an,
    output logic       dp,
    output logic       pm
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [5:0]       snap_h_q, snap_h_d;
    logic [5:0]       snap_m_q, snap_m_d;
    logic [5:0]       snap_s_q, snap_s_d;
    logic [6:0]       seg_q, seg_d;
    logic [5:0]       an_q, an_d;
    logic             dp_q, dp_d;
    logic             pm_q, pm_d;

    logic [5:0] h12;
    logic       h_ok, m_ok, s_ok, pm_n;
    logic [7:0] h_bcd, m_bcd, s_bcd;
    logic [6:0] digit_seg;

    // Tens/units split by compare-and-subtract; valid for 0..63
    function automatic logic [7:0] to_bcd(input logic [5:0] v);
        logic [3:0] t;
        logic [3:0] u;
        if (v >= 6'd60) begin
            t = 4'd6; u = 4'(v - 6'd60);
        end else if (v >= 6'd50) begin
            t = 4'd5; u = 4'(v - 6'd50);
        end else if (v >= 6'd40) begin
            t = 4'd4; u = 4'(v - 6'd40);
        end else if (v >= 6'd30) begin
            t = 4'd3; u = 4'(v - 6'd30);
        end else if (v >= 6'd20) begin
            t = 4'd2; u = 4'(v - 6'd20);
        end else if (v >= 6'd10) begin
            t = 4'd1; u = 4'(v - 6'd10);
        end else begin
            t = 4'd0; u = v[3:0];
        end
        return {t, u};
    endfunction

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    always_comb begin
        h12  = snap_h_q;
        h_ok = 1'b1;
        pm_n = 1'b0;
        if (snap_h_q == 6'd0) begin
            h12 = 6'd12;
        end else if (snap_h_q < 6'd12) begin
            h12 = snap_h_q;
        end else if (snap_h_q == 6'd12) begin
            pm_n = 1'b1;
        end else if (snap_h_q <= 6'd23) begin
            h12  = snap_h_q - 6'd12;
            pm_n = 1'b1;
        end else begin
            h_ok = 1'b0;
        end
        m_ok  = (snap_m_q <= 6'd59);
        s_ok  = (snap_s_q <= 6'd59);
        h_bcd = to_bcd(h12);
        m_bcd = to_bcd(snap_m_q);
        s_bcd = to_bcd(snap_s_q);
    end

    always_comb begin
        digit_seg = SEG_BLANK;
        case (idx_q)
            3'd0: begin
                digit_seg = h_ok ? seg_code(h_bcd[7:4]) : SEG_DASH;
`ifdef LEADING_ZERO_BLANK_EN
                if (h_ok && h_bcd[7:4] == 4'd0) digit_seg = SEG_BLANK;
`endif
            end
            3'd1:    digit_seg = h_ok ? seg_code(h_bcd[3:0]) : SEG_DASH;
            3'd2:    digit_seg = m_ok ? seg_code(m_bcd[7:4]) : SEG_DASH;
            3'd3:    digit_seg = m_ok ? seg_code(m_bcd[3:0]) : SEG_DASH;
            3'd4:    digit_seg = s_ok ? seg_code(s_bcd[7:4]) : SEG_DASH;
            3'd5:    digit_seg = s_ok ? seg_code(s_bcd[3:0]) : SEG_DASH;
            default: digit_seg = SEG_BLANK;
        endcase
    end

    always_comb begin
        cnt_d    = cnt_q + 1'b1;
        idx_d    = idx_q;
        snap_h_d = snap_h_q;
        snap_m_d = snap_m_q;
        snap_s_d = snap_s_q;
        if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
            if (idx_q == 3'd5) begin
                idx_d    = 3'd0;
                snap_h_d = hours;
                snap_m_d = mins;
                snap_s_d = secs;
            end else begin
                idx_d = idx_q + 3'd1;
            end
        end

        // First cycle of every slot is dark so the previous digit cannot ghost
        seg_d = SEG_BLANK;
        an_d  = 6'h3F;
        dp_d  = 1'b0;
        if (cnt_q != '0) begin
            seg_d = digit_seg;
            an_d  = ~(6'b000001 << idx_q);
            dp_d  = (idx_q == 3'd1) || (idx_q == 3'd3) || ((idx_q == 3'd5) && pm_n);
        end
        pm_d = pm_n;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q    <= '0;
            idx_q    <= 3'd0;
            snap_h_q <= 6'd0;
            snap_m_q <= 6'd0;
            snap_s_q <= 6'd0;
            seg_q    <= SEG_BLANK;
            an_q     <= 6'h3F;
            dp_q     <= 1'b0;
            pm_q     <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            snap_h_q <= snap_h_d;
            snap_m_q <= snap_m_d;
            snap_s_q <= snap_s_d;
            seg_q    <= seg_d;
            an_q     <= an_d;
            dp_q     <= dp_d;
            pm_q     <= pm_d;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;
    assign dp  = dp_q;
    assign pm  = pm_q;

endmodule
